// File: rtl/cgmii_frame_sequencer_if.sv
// Control and status bundle between the frame-pacing sequencer and its controller.
// Master drives run control and frame geometry; slave reports state and counters.
// Pure wiring, no storage.
interface cgmii_frame_sequencer_if #(
  parameter int DATA_NBIT  = 8,
  parameter int IDLE_NBIT  = 5,
  parameter int FRAME_NBIT = 16
);
  // run control and per-frame geometry
  logic                  i_enable;
  logic                  i_start;
  logic                  i_stop;
  logic                  i_err_inject;
  logic [IDLE_NBIT-1:0]  i_nidle;
  logic [DATA_NBIT-1:0]  i_ndata;
  logic [FRAME_NBIT-1:0] i_nframes;

  // block-type sequencing towards the encoder and run status
  logic [5:0]            o_state;
  logic                  o_sof;
  logic                  o_eof;
  logic                  o_valid;
  logic                  o_done;
  logic [FRAME_NBIT-1:0] o_frame_count;
  logic [FRAME_NBIT-1:0] o_err_count;

  modport master (
    output i_enable, i_start, i_stop, i_err_inject, i_nidle, i_ndata, i_nframes,
    input  o_state, o_sof, o_eof, o_valid, o_done, o_frame_count, o_err_count
  );

  modport slave (
    input  i_enable, i_start, i_stop, i_err_inject, i_nidle, i_ndata, i_nframes,
    output o_state, o_sof, o_eof, o_valid, o_done, o_frame_count, o_err_count
  );
endinterface

// File: rtl/cgmii_frame_sequencer.sv
// Frame-pacing FSM: sequences idle/start/data/terminate/error blocks for the CGMII encoder.
// State visible one cycle after the deciding input edge; o_valid follows i_enable directly.
// No downstream backpressure: i_enable low freezes every register and the outputs derived from them.
module cgmii_frame_sequencer #(
  parameter int DATA_NBIT  = 8,
  parameter int IDLE_NBIT  = 5,
  parameter int FRAME_NBIT = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  cgmii_frame_sequencer_if.slave   bus
);

  // One-hot encoding is exported unchanged on o_state.
  typedef enum logic [5:0] {
    ST_INIT = 6'b000001,
    ST_TX_C = 6'b000010,
    ST_TX_S = 6'b000100,
    ST_TX_D = 6'b001000,
    ST_TX_T = 6'b010000,
    ST_TX_E = 6'b100000
  } state_t;

  localparam logic [IDLE_NBIT-1:0]  IDLE_ONE  = IDLE_NBIT'(1);
  localparam logic [DATA_NBIT-1:0]  DATA_ONE  = DATA_NBIT'(1);
  localparam logic [FRAME_NBIT-1:0] FRAME_ONE = FRAME_NBIT'(1);

  state_t                state_q,      state_d;
  logic [IDLE_NBIT-1:0]  idle_cnt_q,   idle_cnt_d;
  logic [DATA_NBIT-1:0]  data_cnt_q,   data_cnt_d;
  logic [IDLE_NBIT-1:0]  n_idle_q,     n_idle_d;
  logic [DATA_NBIT-1:0]  n_data_q,     n_data_d;
  logic [FRAME_NBIT-1:0] n_frames_q,   n_frames_d;
  logic [FRAME_NBIT-1:0] frame_cnt_q,  frame_cnt_d;
  logic [FRAME_NBIT-1:0] err_cnt_q,    err_cnt_d;
  logic                  stop_pend_q,  stop_pend_d;
  logic                  done_q,       done_d;

  logic                  run_limit_hit;

  // State and counter registers; reset dominates, then a low enable holds everything.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_INIT;
      idle_cnt_q  <= '0;
      data_cnt_q  <= '0;
      n_idle_q    <= '0;
      n_data_q    <= '0;
      n_frames_q  <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.i_enable) begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      data_cnt_q  <= data_cnt_d;
      n_idle_q    <= n_idle_d;
      n_data_q    <= n_data_d;
      n_frames_q  <= n_frames_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // The run ends at the frame that brings the completed count up to a nonzero target.
  assign run_limit_hit = (n_frames_q != '0) && ((frame_cnt_q + FRAME_ONE) == n_frames_q);

  // Next-state and counter logic; error injection outranks the normal S/D progressions.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    data_cnt_d  = data_cnt_q;
    n_idle_d    = n_idle_q;
    n_data_d    = n_data_q;
    n_frames_d  = n_frames_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    done_d      = 1'b0;
    // A stop request is remembered for the rest of the run; it is meaningless while idle.
    stop_pend_d = stop_pend_q | (bus.i_stop && (state_q != ST_INIT));

    case (state_q)
      ST_INIT: begin
        stop_pend_d = 1'b0;
        if (bus.i_start) begin
          n_idle_d    = bus.i_nidle;
          n_data_d    = bus.i_ndata;
          n_frames_d  = bus.i_nframes;
          frame_cnt_d = '0;
          err_cnt_d   = '0;
          idle_cnt_d  = '0;
          data_cnt_d  = '0;
          state_d     = ST_TX_C;
        end
      end

      ST_TX_C: begin
        if (idle_cnt_q == n_idle_q) begin
          idle_cnt_d = '0;
          state_d    = ST_TX_S;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_ONE;
        end
      end

      ST_TX_S: begin
        if (bus.i_err_inject) begin
          data_cnt_d = '0;
          state_d    = ST_TX_E;
        end else begin
          state_d    = ST_TX_D;
        end
      end

      ST_TX_D: begin
        if (bus.i_err_inject) begin
          data_cnt_d = '0;
          state_d    = ST_TX_E;
        end else if (data_cnt_q == n_data_q) begin
          data_cnt_d = '0;
          state_d    = ST_TX_T;
        end else begin
          data_cnt_d = data_cnt_q + DATA_ONE;
        end
      end

      ST_TX_T: begin
        frame_cnt_d = frame_cnt_q + FRAME_ONE;
        if (run_limit_hit || stop_pend_q || bus.i_stop) begin
          stop_pend_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_INIT;
        end else begin
          // Geometry changes only take effect between frames.
          n_idle_d    = bus.i_nidle;
          n_data_d    = bus.i_ndata;
          state_d     = ST_TX_C;
        end
      end

      ST_TX_E: begin
        // The aborted frame is not counted; pacing restarts with a full IPG.
        err_cnt_d  = err_cnt_q + FRAME_ONE;
        idle_cnt_d = '0;
        data_cnt_d = '0;
        state_d    = ST_TX_C;
      end

      default: begin
        // Corrupted state: emit an error block so the encoder sees a clean abort.
        idle_cnt_d = '0;
        data_cnt_d = '0;
        state_d    = ST_TX_E;
      end
    endcase
  end

  assign bus.o_state       = state_q;
  assign bus.o_sof         = (state_q == ST_TX_S);
  assign bus.o_eof         = (state_q == ST_TX_T);
  assign bus.o_valid       = bus.i_enable && (state_q != ST_INIT);
  assign bus.o_done        = done_q;
  assign bus.o_frame_count = frame_cnt_q;
  assign bus.o_err_count   = err_cnt_q;

endmodule
